// File: rtl/pad_byte_tx.sv
// pad_byte_tx: buffers core bytes and sends them to the padframe with a four-phase strobe/ack handshake.
// Latency: a byte reaches io_out[15:8] 2 cycles after push; strobe rises SETUP_CYC cycles later.
// Backpressure: tx_ready drops when the FIFO is full or reset is high; a slow ack stalls the drain.

// Small generic FIFO used to buffer bytes ahead of the handshake engine.
// Latency: data visible on out_dat one cycle after push; pop takes effect on the next edge.
// Backpressure: in_rdy low when full; out_vld low when empty.
module pad_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign in_rdy  = (count != CW'(DEPTH));
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module pad_byte_tx #(
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        enable,
  input  logic        err_clr,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [15:0] oeb,
  output logic        busy,
  output logic        timeout_err
);
  localparam int MAXC = (SETUP_CYC > TIMEOUT_CYC) ? SETUP_CYC : TIMEOUT_CYC;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] SETUP_LAST   = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT_HI, WAIT_LO, RECOVER} state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          err_set;
  logic          ack_meta, ack_s;
  logic          fifo_in_rdy;
  logic          fifo_vld;
  logic          pop;
  logic [7:0]    fifo_dat;
  logic          drive;
  logic          unused_io;

  // Only the ack pin is meaningful; the rest of the pad inputs belong to the receive path.
  assign unused_io = ^{io_in[15:8], io_in[6:0]};

  pad_byte_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (tx_valid),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (tx_data),
    .out_vld (fifo_vld),
    .out_rdy (pop),
    .out_dat (fifo_dat)
  );

  // Ack comes from another clock domain off-chip: two-flop synchroniser before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= io_in[7];
      ack_s    <= ack_meta;
    end
  end

  // FSM state, shared timer and registered pad outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state logic; the timer restarts from zero on every state entry.
  always_comb begin
    state_d  = state;
    timer_d  = timer + TW'(1);
    data_d   = data_q;
    strobe_d = strobe_q;
    err_set  = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        strobe_d = 1'b0;
        timer_d  = '0;
        // A high ack here means the receiver has not finished the previous cycle.
        if (enable && fifo_vld && !ack_s) begin
          pop     = 1'b1;
          data_d  = fifo_dat;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (timer == SETUP_LAST) begin
          strobe_d = 1'b1;
          state_d  = WAIT_HI;
          timer_d  = '0;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          strobe_d = 1'b0;
          state_d  = WAIT_LO;
          timer_d  = '0;
        end else if (timer == TIMEOUT_LAST) begin
          strobe_d = 1'b0;
          err_set  = 1'b1;
          state_d  = RECOVER;
          timer_d  = '0;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer == TIMEOUT_LAST) begin
          err_set = 1'b1;
          state_d = RECOVER;
          timer_d = '0;
        end
      end
      RECOVER: begin
        // The timed-out byte is abandoned; just wait for the line to go quiet.
        timer_d  = '0;
        strobe_d = 1'b0;
        if (!ack_s) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        timer_d  = '0;
        strobe_d = 1'b0;
      end
    endcase
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        timeout_err <= 1'b0;
    else if (err_set) timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

  // Pads stay driven until an in-flight byte finishes even if enable drops.
  assign drive    = !reset && (enable || (state != IDLE));
  assign io_out   = {data_q, 1'b0, strobe_q, 6'b000000};
  assign oeb      = {{8{!drive}}, 1'b1, !drive, 6'b111111};
  assign busy     = (state != IDLE) || fifo_vld;
  assign tx_ready = fifo_in_rdy && !reset;
endmodule

// File: tb/tb_pad_byte_tx.sv
module tb_pad_byte_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        enable;
  logic        err_clr;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic [15:0] oeb;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  // Receiver model: 0 = bench drives ack, 1 = ack follows strobe, 2 = ack latches high on strobe.
  int         ack_mode = 0;
  logic       prev_strobe = 1'b0;
  int         hi_cnt = 0;
  int         last_hi_len = 0;
  logic [7:0] byte_q[$];

  always #5 clk = ~clk;

  pad_byte_tx #(.DEPTH(4), .SETUP_CYC(2), .TIMEOUT_CYC(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .enable      (enable),
    .err_clr     (err_clr),
    .io_in       (io_in),
    .io_out      (io_out),
    .oeb         (oeb),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        en;
    logic        ack;
    logic [15:0] exp_out;
    logic [15:0] exp_oeb;
    logic        exp_rdy;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, then the receiver model reacts.
  task automatic tick();
    @(posedge clk);
    #1;
    if (io_out[6] && !prev_strobe) byte_q.push_back(io_out[15:8]);
    if (io_out[6]) hi_cnt++;
    else if (prev_strobe) begin
      last_hi_len = hi_cnt;
      hi_cnt = 0;
    end
    prev_strobe = io_out[6];
    if (ack_mode == 1) io_in[7] = io_out[6];
    else if (ack_mode == 2 && io_out[6]) io_in[7] = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 0);
  endtask

  task automatic wait_strobe(input logic lvl, input int budget, input string name);
    int n = 0;
    while (io_out[6] !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(io_out[6]), 32'(lvl));
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //            vld   dat    en    ack   io_out      oeb         rdy   busy  err
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 16'h0000, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA500, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA500, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA540, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'hA540, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'hA540, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'hA500, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA500, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA500, 16'h00BF, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA500, 16'h00BF, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hA500, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    enable   = 1'b0;
    err_clr  = 1'b0;
    io_in    = 16'hFF7F;
    tick();
    tick();
    check("reset io_out", 32'(io_out), 'h0000);
    check("reset oeb", 32'(oeb), 'hFFFF);
    check("reset tx_ready", 32'(tx_ready), 0);
    check("reset busy", 32'(busy), 0);
    check("reset timeout_err", 32'(timeout_err), 0);
    reset = 1'b0;
    #1;
    check("post-reset tx_ready", 32'(tx_ready), 1);

    // Single byte with a prompt receiver, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      tx_valid = vecs[i].vld;
      tx_data  = vecs[i].dat;
      enable   = vecs[i].en;
      io_in[7] = vecs[i].ack;
      tick();
      check($sformatf("vec%0d io_out", i), 32'(io_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d oeb", i), 32'(oeb), 32'(vecs[i].exp_oeb));
      check($sformatf("vec%0d tx_ready", i), 32'(tx_ready), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].exp_err));
    end
    check("vec strobe pulse length", 32'(last_hi_len), 3);

    // Fill the FIFO while disabled, then drain in order.
    for (int i = 0; i < 5; i++) begin
      tx_data  = 8'hB0 + 8'(i);
      tx_valid = 1'b1;
      check($sformatf("fill%0d tx_ready", i), 32'(tx_ready), (i < 4) ? 1 : 0);
      tick();
    end
    tx_valid = 1'b0;
    check("fill oeb", 32'(oeb), 'hFFFF);
    check("fill busy", 32'(busy), 1);
    check("fill full tx_ready", 32'(tx_ready), 0);
    byte_q.delete();
    ack_mode = 1;
    enable   = 1'b1;
    wait_idle(300, "drain idle");
    check("drain count", 32'(byte_q.size()), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("drain byte%0d", i), 32'(byte_q[i]), 'hB0 + i);
    check("drain tx_ready", 32'(tx_ready), 1);

    // Receiver never acks: WAIT_HI timeout.
    ack_mode = 0;
    io_in[7] = 1'b0;
    push_byte(8'hC1);
    wait_strobe(1'b1, 50, "hi-timeout strobe rise");
    wait_strobe(1'b0, 400, "hi-timeout strobe fall");
    check("hi-timeout strobe length", 32'(last_hi_len), 255);
    check("hi-timeout err", 32'(timeout_err), 1);
    ack_mode = 1;
    push_byte(8'hC2);
    wait_idle(200, "hi-timeout next idle");
    check("hi-timeout next byte", 32'(byte_q[$]), 'hC2);
    check("hi-timeout err sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr clears", 32'(timeout_err), 0);

    // Ack stuck high: WAIT_LO timeout, with err_clr held so the set must win.
    ack_mode = 2;
    err_clr  = 1'b1;
    tx_data  = 8'hD4;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hD5;
    tick();
    tx_valid = 1'b0;
    cnt = 0;
    while (!timeout_err && cnt < 700) begin
      tick();
      cnt++;
    end
    err_clr = 1'b0;
    check("lo-timeout err beats clr", 32'(timeout_err), 1);
    check("lo-timeout strobe low", 32'(io_out[6]), 0);
    check("lo-timeout byte sent", 32'(byte_q[$]), 'hD4);
    cnt = byte_q.size();
    repeat (10) tick();
    check("recover no new byte", 32'(byte_q.size()), 32'(cnt));
    check("recover strobe low", 32'(io_out[6]), 0);
    check("recover busy", 32'(busy), 1);
    check("recover err held", 32'(timeout_err), 1);
    ack_mode = 1;
    io_in[7] = 1'b0;
    wait_idle(200, "recover resume idle");
    check("recover resume byte", 32'(byte_q[$]), 'hD5);
    check("recover resume count", 32'(byte_q.size()), 32'(cnt + 1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Enable dropped mid-transfer.
    push_byte(8'hE7);
    wait_strobe(1'b1, 50, "en-drop strobe rise");
    enable = 1'b0;
    tick();
    check("en-drop pads still driven", 32'(oeb), 'h00BF);
    wait_idle(100, "en-drop idle");
    check("en-drop byte", 32'(byte_q[$]), 'hE7);
    check("en-drop pads released", 32'(oeb), 'hFFFF);

    // Reset mid-transfer.
    enable = 1'b1;
    push_byte(8'hF0);
    push_byte(8'hF1);
    push_byte(8'hF2);
    wait_strobe(1'b1, 50, "rst strobe rise");
    reset = 1'b1;
    #1;
    check("rst async io_out", 32'(io_out), 'h0000);
    check("rst async oeb", 32'(oeb), 'hFFFF);
    check("rst async tx_ready", 32'(tx_ready), 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst release tx_ready", 32'(tx_ready), 1);
    check("rst release busy", 32'(busy), 0);
    cnt = byte_q.size();
    repeat (30) tick();
    check("rst fifo flushed", 32'(byte_q.size()), 32'(cnt));
    check("rst strobe quiet", 32'(io_out[6]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
